mem_arbiter: RTL and testbench

- Shares one single-ported unified memory between the pipeline's instruction-fetch port and its load/store port.
- Arbitrates between the two requesters, sequences each memory transaction with a req/ack handshake, and returns read data plus a one-cycle ready pulse to the winner.
- Sits between the processor core and a unified memory. It replaces the split instruction/data memories when the design moves to a single multi-cycle memory.

---
 rtl/mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Fetch/load-store arbiter in front of one single-ported memory.
//            Define ARB_TIMEOUT_EN to abort stalled accesses after TIMEOUT.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          owner,
    output logic          err
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_ACK = 2'd1,
        S_RESP     = 2'd2
    } state_t;

    localparam logic [31:0] c_dead = 32'hDEADBEEF;

    state_t        r_state, w_state_nxt;
    logic          r_owner, w_owner_nxt;
    logic          r_mem_we, w_mem_we_nxt;
    logic [AW-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DW-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [DW-1:0] r_i_rdata, w_i_rdata_nxt;
    logic [DW-1:0] r_d_rdata, w_d_rdata_nxt;
    logic [DW-1:0] w_resp_data;
    logic          w_grant_d;
    logic          w_grant_i;
    logic          w_timeout;
    logic          w_unused_addr_lsbs;

    generate
        if (TIMEOUT < 2) begin : g_bad_timeout
            $error("mem_arbiter: TIMEOUT must be at least 2");
        end
    endgenerate

    // Word alignment discards the byte offset of both request addresses.
    assign w_unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};

`ifdef ARB_TIMEOUT_EN
    localparam int                 c_cnt_w    = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_err;

    // A late ack in the final allowed cycle still completes normally.
    assign w_timeout = (r_state == S_WAIT_ACK) && !mem_ack && (r_cnt == c_cnt_last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if ((w_state_nxt == S_WAIT_ACK) && (r_state != S_WAIT_ACK)) begin
                r_cnt <= '0;
            end else if ((r_state == S_WAIT_ACK) && !mem_ack) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_owner     <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_i_rdata   <= w_i_rdata_nxt;
            r_d_rdata   <= w_d_rdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_i_rdata_nxt   = r_i_rdata;
        w_d_rdata_nxt   = r_d_rdata;
        w_grant_d       = 1'b0;
        w_grant_i       = 1'b0;
        w_resp_data     = w_timeout ? DW'(c_dead) : mem_rdata;

        case (r_state)
            S_IDLE: begin
                if (d_req) begin
                    w_grant_d = 1'b1;
                end else if (i_req) begin
                    w_grant_i = 1'b1;
                end
            end
            S_WAIT_ACK: begin
                if (mem_ack || w_timeout) begin
                    if (r_owner) begin
                        w_i_rdata_nxt = w_resp_data;
                    end else if (!r_mem_we || w_timeout) begin
                        w_d_rdata_nxt = w_resp_data;
                    end
                    w_mem_we_nxt = 1'b0;
                    w_state_nxt  = S_RESP;
                end
            end
            S_RESP: begin
                // The port being answered still shows its old req; only the other may win.
                w_state_nxt = S_IDLE;
                if (r_owner) begin
                    w_grant_d = d_req;
                end else begin
                    w_grant_i = i_req;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_grant_d) begin
            w_owner_nxt     = 1'b0;
            w_mem_we_nxt    = d_we;
            w_mem_addr_nxt  = {d_addr[AW-1:2], 2'b00};
            w_mem_wdata_nxt = d_wdata;
            w_state_nxt     = S_WAIT_ACK;
        end else if (w_grant_i) begin
            w_owner_nxt     = 1'b1;
            w_mem_we_nxt    = 1'b0;
            w_mem_addr_nxt  = {i_addr[AW-1:2], 2'b00};
            w_mem_wdata_nxt = d_wdata;
            w_state_nxt     = S_WAIT_ACK;
        end
    end

    assign mem_req   = (r_state == S_WAIT_ACK);
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign owner     = r_owner;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign i_ready   = (r_state == S_RESP) && r_owner;
    assign d_ready   = (r_state == S_RESP) && !r_owner;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter: directed cases plus random
//            traffic compared against a transaction-level model every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_rdata;
    logic          i_ready;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic          owner;
    logic          err;

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .owner(owner), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding access, plus who is answered this cycle.
    bit            m_busy;
    int            m_served;   // -1 none, 0 data, 1 fetch
    int            m_waited;
    bit            m_owner;
    bit            m_we;
    bit            m_err;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_i_rdata;
    logic [DW-1:0] m_d_rdata;

    task automatic model_reset();
        m_busy = 0; m_served = -1; m_waited = 0; m_owner = 0; m_we = 0; m_err = 0;
        m_addr = '0; m_wdata = '0; m_i_rdata = '0; m_d_rdata = '0;
    endtask

    task automatic model_grant(input bit fetch);
        m_owner  = fetch;
        m_addr   = fetch ? (i_addr & ~32'h3) : (d_addr & ~32'h3);
        m_we     = fetch ? 1'b0 : d_we;
        m_wdata  = d_wdata;
        m_busy   = 1;
        m_waited = 0;
    endtask

    task automatic model_finish(input bit timed_out);
        logic [DW-1:0] data;
        data = timed_out ? 32'hDEADBEEF : mem_rdata;
        if (m_owner) m_i_rdata = data;
        else if (!m_we || timed_out) m_d_rdata = data;
        m_served = m_owner ? 1 : 0;
        m_err    = timed_out;
        m_busy   = 0;
        m_we     = 0;
    endtask

    task automatic model_step();
        bit want_d, want_i;
        if (m_busy) begin
            if (mem_ack) model_finish(1'b0);
            else if (TO_EN && (m_waited + 1 >= TMO)) model_finish(1'b1);
            else m_waited++;
        end else begin
            want_d   = d_req && (m_served != 0);
            want_i   = i_req && (m_served != 1);
            m_served = -1;
            m_err    = 0;
            if (want_d) model_grant(1'b0);
            else if (want_i) model_grant(1'b1);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("cyc_mem_req",   mem_req,   m_busy);
                check("cyc_mem_we",    mem_we,    m_we);
                check("cyc_mem_addr",  mem_addr,  m_addr);
                check("cyc_mem_wdata", mem_wdata, m_wdata);
                check("cyc_owner",     owner,     m_owner);
                check("cyc_i_ready",   i_ready,   m_served == 1);
                check("cyc_d_ready",   d_ready,   m_served == 0);
                check("cyc_i_rdata",   i_rdata,   m_i_rdata);
                check("cyc_d_rdata",   d_rdata,   m_d_rdata);
                check("cyc_err",       err,       m_err);
            end
        end
    end

    // Memory responder: ack after a chosen number of extra wait cycles.
    int            rsp_lo = 0;
    int            rsp_hi = 0;
    bit            rsp_fixed = 1'b1;
    bit            rsp_spurious = 1'b0;
    logic [DW-1:0] rsp_data = '0;

    initial begin
        int wait_left;
        wait_left = -1;
        forever begin
            @(posedge clk);
            #2;
            mem_rdata = rsp_fixed ? rsp_data : DW'($urandom);
            if (!mem_req) begin
                wait_left = -1;
                mem_ack   = rsp_spurious && ($urandom_range(0, 3) == 0);
            end else begin
                if (wait_left < 0) wait_left = int'($urandom_range(rsp_hi, rsp_lo));
                if (wait_left == 0) begin
                    mem_ack   = 1'b1;
                    wait_left = -1;
                end else begin
                    mem_ack = 1'b0;
                    wait_left--;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic new_d();
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = $urandom;
        d_wdata = $urandom;
    endtask

    task automatic new_i();
        i_req  = 1'b1;
        i_addr = $urandom;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        cmp_en = 1'b1;
        @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_owner",   owner,   0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_i_ready", i_ready, 0);
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);

        // Load alone
        rsp_data = 32'h12345678; rsp_lo = 0; rsp_hi = 0;
        d_req = 1; d_we = 0; d_addr = 32'h43; d_wdata = '0;
        tick(); @(negedge clk);
        check("ld_mem_req",  mem_req,  1);
        check("ld_mem_addr", mem_addr, 32'h40);
        check("ld_early_rdy", d_ready, 0);
        tick(); @(negedge clk);
        check("ld_d_ready", d_ready, 1);
        check("ld_d_rdata", d_rdata, 32'h12345678);
        check("ld_i_ready", i_ready, 0);
        check("ld_model_rdata", m_d_rdata, 32'h12345678);
        d_req = 0;
        tick(); @(negedge clk);
        check("ld_ready_once", d_ready, 0);

        // Simultaneous requests: data first, then fetch granted from RESP
        rsp_data = 32'h0BADF00D;
        d_req = 1; d_addr = 32'h200; i_req = 1; i_addr = 32'h100;
        tick(); @(negedge clk);
        check("sim_owner0", owner, 0);
        check("sim_addr0",  mem_addr, 32'h200);
        tick(); @(negedge clk);
        check("sim_d_ready", d_ready, 1);
        check("sim_i_ready0", i_ready, 0);
        d_req = 0;
        tick(); @(negedge clk);
        check("sim_owner1", owner, 1);
        check("sim_addr1",  mem_addr, 32'h100);
        check("sim_req1",   mem_req, 1);
        tick(); @(negedge clk);
        check("sim_i_ready", i_ready, 1);
        check("sim_i_rdata", i_rdata, 32'h0BADF00D);
        check("sim_model_owner", m_owner, 1);
        i_req = 0;
        tick(); @(negedge clk);

        // Store
        rsp_data = 32'h11111111;
        d_req = 1; d_we = 1; d_addr = 32'h44; d_wdata = 32'hCAFEF00D;
        tick(); @(negedge clk);
        check("st_mem_we",    mem_we,    1);
        check("st_mem_wdata", mem_wdata, 32'hCAFEF00D);
        check("st_mem_addr",  mem_addr,  32'h44);
        tick(); @(negedge clk);
        check("st_d_ready", d_ready, 1);
        check("st_d_rdata", d_rdata, 32'h0BADF00D);
        check("st_mem_we_drop", mem_we, 0);
        d_req = 0; d_we = 0;
        tick(); @(negedge clk);

        // Slow memory: five wait cycles
        rsp_lo = 4; rsp_hi = 4; rsp_data = 32'h77665544;
        i_req = 1; i_addr = 32'h1237;
        for (int k = 0; k < 5; k++) begin
            tick(); @(negedge clk);
            check("slow_req",  mem_req,  1);
            check("slow_addr", mem_addr, 32'h1234);
            check("slow_we",   mem_we,   0);
            check("slow_rdy",  i_ready,  0);
        end
        tick(); @(negedge clk);
        check("slow_i_ready", i_ready, 1);
        check("slow_i_rdata", i_rdata, 32'h77665544);
        i_req = 0;
        tick(); @(negedge clk);

        // Reset in the middle of a wait
        rsp_lo = 20; rsp_hi = 20;
        d_req = 1; d_addr = 32'h80;
        tick(); tick(); @(negedge clk);
        check("rstw_req_before", mem_req, 1);
        reset = 0;
        #1;
        check("rstw_req_async", mem_req, 0);
        d_req = 0;
        tick(); tick();
        reset = 1;
        for (int k = 0; k < 3; k++) begin
            tick(); @(negedge clk);
            check("rstw_no_ready", d_ready, 0);
        end
        rsp_lo = 0; rsp_hi = 0; rsp_data = 32'h13579BDF;
        d_req = 1; d_addr = 32'h88;
        tick(); tick(); @(negedge clk);
        check("rstw_new_ready", d_ready, 1);
        check("rstw_new_rdata", d_rdata, 32'h13579BDF);
        d_req = 0;
        tick(); @(negedge clk);

`ifdef ARB_TIMEOUT_EN
        // Ack in the last allowed cycle wins over the timeout
        rsp_lo = TMO - 1; rsp_hi = TMO - 1; rsp_data = 32'h5A5A5A5A;
        i_req = 1; i_addr = 32'h300;
        repeat (TMO) tick();
        tick(); @(negedge clk);
        check("tol_i_ready", i_ready, 1);
        check("tol_err",     err,     0);
        check("tol_i_rdata", i_rdata, 32'h5A5A5A5A);
        i_req = 0;
        tick(); @(negedge clk);

        // No ack at all: abort after TMO cycles
        rsp_lo = 100; rsp_hi = 100;
        i_req = 1; i_addr = 32'h304;
        for (int k = 0; k < TMO; k++) begin
            tick(); @(negedge clk);
            check("to_req_held", mem_req, 1);
        end
        tick(); @(negedge clk);
        check("to_req_drop", mem_req, 0);
        check("to_err",      err,     1);
        check("to_i_ready",  i_ready, 1);
        check("to_i_rdata",  i_rdata, 32'hDEADBEEF);
        i_req = 0;
        tick(); @(negedge clk);
        check("to_err_pulse", err, 0);
`endif

        // Random traffic against the model
        rsp_fixed = 0; rsp_spurious = 1; rsp_lo = 0; rsp_hi = TO_EN ? 10 : 6;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (c == 1500) reset = 0;
            if (c == 1502) reset = 1;
            if (d_req && d_ready) begin
                if ($urandom_range(0, 1) == 0) d_req = 0;
                else new_d();
            end else if (!d_req && ($urandom_range(0, 2) == 0)) begin
                new_d();
            end
            if (i_req && i_ready) begin
                if ($urandom_range(0, 1) == 0) i_req = 0;
                else new_i();
            end else if (!i_req && ($urandom_range(0, 2) == 0)) begin
                new_i();
            end
        end
        d_req = 0; i_req = 0;
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
